mult_product_accumulator: RTL and testbench

Downstream consumer of pipelined_multiplier. Takes the multiplier's product/valid stream and sums groups of LEN consecutive products (dot-product style). Completed sums go to a one-entry output register with a valid/ready handshake. The multiplier has no backpressure, so this block never stalls its input; it flags any result it has to drop.

---
 rtl/mult_product_accumulator.sv | 130 +++++++++++++
 tb/tb_mult_product_accumulator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult_product_accumulator.sv
// mult_product_accumulator
// Sums groups of LEN consecutive products from pipelined_multiplier. Each
// group total is saturated at 2^ACC_W-1. A finished group goes into a
// one-entry output register that the consumer reads with a valid/ready
// handshake. The input stream is never stalled. If the output register is
// still occupied when a group finishes, that new group is discarded and the
// sticky drop_err flag is set.
//
// Ports:
//   clk, reset             rising-edge clock; synchronous active-high reset
//   in_valid, in_product   product stream from the multiplier
//   flush                  close the current partial group
//   out_ready              consumer accepts the output register
//   out_valid              out_sum/out_count/out_sat are valid
//   out_sum                saturated group sum
//   out_count              number of products in the emitted group
//   out_sat                the emitted group saturated
//   busy                   a partial group is in progress (registered)
//   drop_err               sticky: a completed group was discarded
module mult_product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned LEN    = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_product,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output logic              busy,
  output logic              drop_err
);

  localparam int unsigned      SUM_W   = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LEN - 1);

  typedef enum logic {EMPTY, FULL} ostate_t;

  ostate_t          state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             grp_sat;

  logic [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_upd;
  logic             close;
  logic             load;
  logic             drop;

  // Post-update view of the group, including this cycle's product if it is valid.
  // The sum is one bit wider than the accumulator so that overflow is visible in the top bit.
  always_comb begin
    sum_ext = SUM_W'(acc) + SUM_W'(in_product);
    acc_upd = acc;
    sat_upd = grp_sat;
    cnt_upd = count;
    if (in_valid) begin
      acc_upd = sum_ext[ACC_W] ? ACC_MAX : sum_ext[ACC_W-1:0];
      sat_upd = grp_sat | sum_ext[ACC_W];
      cnt_upd = count + CNT_W'(1);
    end
    close   = (in_valid && (count == LAST)) || (flush && (cnt_upd != '0));
    cnt_nxt = close ? '0 : cnt_upd;
  end

  // Output register control. A close while FULL is accepted only if the
  // current contents are being popped in the same cycle; otherwise the new group is dropped.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (close) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (close) begin
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      acc       <= '0;
      count     <= '0;
      grp_sat   <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= close ? '0 : acc_upd;
      grp_sat <= close ? 1'b0 : sat_upd;
      count   <= cnt_nxt;
      busy    <= (cnt_nxt != '0);
      if (load) begin
        out_sum   <= acc_upd;
        out_count <= cnt_upd;
        out_sat   <= sat_upd;
      end
      if (drop) drop_err <= 1'b1;
    end
  end

  // out_valid is decoded directly from the state flop.
  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed-vector bench for mult_product_accumulator. It drives a default
// instance (ACC_W=12) and a narrow instance (ACC_W=9) from the same stimulus,
// so that saturation can be checked alongside normal accumulation.
module tb_mult_product_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_product;
  logic       flush;
  logic       out_ready;

  logic        out_valid,  out_sat,  busy,  drop_err;
  logic [11:0] out_sum;
  logic [2:0]  out_count;

  logic        out_valid9, out_sat9, busy9, drop_err9;
  logic [8:0]  out_sum9;
  logic [2:0]  out_count9;

  int n_checks = 0;
  int n_fail   = 0;

  mult_product_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_product(in_product),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat),
    .busy(busy), .drop_err(drop_err)
  );

  mult_product_accumulator #(.ACC_W(9)) dut9 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_product(in_product),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid9),
    .out_sum(out_sum9), .out_count(out_count9), .out_sat(out_sat9),
    .busy(busy9), .drop_err(drop_err9)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Apply one cycle of input, then sample 1 time unit after the clock edge.
  task automatic step(input logic v, input logic [7:0] p, input logic f);
    in_valid   = v;
    in_product = p;
    flush      = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 8'd0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_product = '0; flush = 1'b0; out_ready = 1'b1;
    #2;

    // Reset state
    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_sum",   32'(out_sum),   0);
    check("rst_count", 32'(out_count), 0);
    check("rst_sat",   32'(out_sat),   0);
    check("rst_busy",  32'(busy),      0);
    check("rst_drop",  32'(drop_err),  0);

    // Basic group: 4 x 15 with idle cycles in between
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd15, 1'b0);
      check("basic_busy",  32'(busy), 1);
      check("basic_novld", 32'(out_valid), 0);
      step(1'b0, 8'd0, 1'b0);
    end
    step(1'b1, 8'd15, 1'b0);
    check("basic_valid", 32'(out_valid), 1);
    check("basic_sum",   32'(out_sum),   60);
    check("basic_count", 32'(out_count), 4);
    check("basic_sat",   32'(out_sat),   0);
    check("basic_busy0", 32'(busy),      0);
    step(1'b0, 8'd0, 1'b0);
    check("basic_pop",   32'(out_valid), 0);

    // Flush of a partial group
    step(1'b1, 8'd15, 1'b0);
    step(1'b1, 8'd225, 1'b0);
    check("flush_novld", 32'(out_valid), 0);
    step(1'b0, 8'd0, 1'b1);
    check("flush_valid", 32'(out_valid), 1);
    check("flush_sum",   32'(out_sum),   240);
    check("flush_count", 32'(out_count), 2);
    step(1'b0, 8'd0, 1'b0);
    check("flush_pop",   32'(out_valid), 0);
    // A flush with an empty group does nothing
    step(1'b0, 8'd0, 1'b1);
    check("flush0_novld", 32'(out_valid), 0);
    check("flush0_busy",  32'(busy),      0);
    // A flush in the same cycle as the 3rd product includes that product
    step(1'b1, 8'd15, 1'b0);
    step(1'b1, 8'd15, 1'b0);
    step(1'b1, 8'd15, 1'b1);
    check("coflush_valid", 32'(out_valid), 1);
    check("coflush_sum",   32'(out_sum),   45);
    check("coflush_count", 32'(out_count), 3);
    check("coflush_busy",  32'(busy),      0);
    step(1'b0, 8'd0, 1'b0);

    // Backpressure: group B is dropped while group A is held
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0);
    check("bpA_valid", 32'(out_valid), 1);
    check("bpA_sum",   32'(out_sum),   4);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd2, 1'b0);
    check("bpB_valid", 32'(out_valid), 1);
    check("bpB_hold",  32'(out_sum),   4);
    check("bpB_cnt",   32'(out_count), 4);
    check("bpB_drop",  32'(drop_err),  1);
    out_ready = 1'b1;
    step(1'b0, 8'd0, 1'b0);
    check("bp_pop",      32'(out_valid), 0);
    check("bp_sticky",   32'(drop_err),  1);

    // Pop and close in the same cycle: B replaces A, with no drop
    do_reset();
    check("bp2_rstdrop", 32'(drop_err), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd2, 1'b0);
    check("bp2_holdA", 32'(out_sum), 4);
    out_ready = 1'b1;
    step(1'b1, 8'd2, 1'b0);
    check("bp2_valid", 32'(out_valid), 1);
    check("bp2_sum",   32'(out_sum),   8);
    check("bp2_drop",  32'(drop_err),  0);
    step(1'b0, 8'd0, 1'b0);
    check("bp2_pop",   32'(out_valid), 0);

    // Saturation (ACC_W=9 instance); the 12-bit instance holds 900 without saturating
    for (int i = 0; i < 4; i++) step(1'b1, 8'd225, 1'b0);
    check("sat9_valid", 32'(out_valid9), 1);
    check("sat9_sum",   32'(out_sum9),   511);
    check("sat9_sat",   32'(out_sat9),   1);
    check("sat9_cnt",   32'(out_count9), 4);
    check("sat12_sum",  32'(out_sum),    900);
    check("sat12_sat",  32'(out_sat),    0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0);
    check("sat9_next_sum", 32'(out_sum9), 4);
    check("sat9_next_sat", 32'(out_sat9), 0);
    step(1'b0, 8'd0, 1'b0);

    // Reset in the middle of a group discards the partial sum
    step(1'b1, 8'd100, 1'b0);
    step(1'b1, 8'd100, 1'b0);
    check("midrst_busy", 32'(busy), 1);
    do_reset();
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_drop",  32'(drop_err),  0);
    check("midrst_busy0", 32'(busy),      0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd10, 1'b0);
    check("midrst_sum",   32'(out_sum),   40);
    check("midrst_count", 32'(out_count), 4);
    step(1'b0, 8'd0, 1'b0);

    // Back-to-back: 8 consecutive products form two groups
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'd15, 1'b0);
      if (i == 3 || i == 7) begin
        check("b2b_valid", 32'(out_valid), 1);
        check("b2b_sum",   32'(out_sum),   60);
        check("b2b_count", 32'(out_count), 4);
      end else begin
        check("b2b_novld", 32'(out_valid), 0);
      end
    end
    check("b2b_drop", 32'(drop_err), 0);
    step(1'b0, 8'd0, 1'b0);
    check("b2b_pop",  32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
